// File: rtl/craft_pkg.sv
// Shared constants, Q permutation table and FSM state encoding for the
// CRAFT tweakey generator.
package craft_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int NUM_NIBBLES = 16;
  localparam int BLOCK_W     = NIBBLE_W * NUM_NIBBLES;

  // Q permutation: output nibble j takes input nibble P[j].
  // Nibble 0 sits in bits 63:60, so entry j is stored at bits 63-4j -: 4.
  localparam logic [BLOCK_W-1:0] P_TABLE = 64'hCAF5_E892_B374_601D;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Source nibble index feeding output nibble j of Q.
  function automatic int unsigned p_src(input int unsigned j);
    logic [NIBBLE_W-1:0] entry;
    entry = P_TABLE[BLOCK_W-1-NIBBLE_W*j -: NIBBLE_W];
    return {28'd0, entry};
  endfunction

endpackage

// File: rtl/craft_q_perm.sv
// Purely combinational CRAFT tweak permutation Q (nibble shuffle).
module craft_q_perm
  import craft_pkg::*;
(
  input  logic [BLOCK_W-1:0] t_in,
  output logic [BLOCK_W-1:0] q_out
);

  for (genvar j = 0; j < NUM_NIBBLES; j++) begin : g_nib
    localparam int unsigned SRC = p_src(j);
    assign q_out[BLOCK_W-1-NIBBLE_W*j -: NIBBLE_W] =
      t_in[BLOCK_W-1-NIBBLE_W*SRC -: NIBBLE_W];
  end

endmodule

// File: rtl/craft_tweakey_gen.sv
// CRAFT round tweakey generator: on start, latches key/tweak/Q(tweak) and
// streams ROUNDS tweakeys (forward or reverse order) over a valid/ready port.
//
// Handshake: tk_valid is high for the whole RUN state and tk/tk_round/tk_last
// are stable while tk_valid=1 and tk_ready=0; a transfer happens on a rising
// edge where tk_valid and tk_ready are both high. start is only honoured when
// ready=1 (IDLE); start in RUN is dropped.
module craft_tweakey_gen
  import craft_pkg::*;
#(
  parameter int ROUNDS   = 32,
  parameter int TWEAK_EN = 1,
  parameter int RW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          decrypt,
  input  logic [127:0]  key,
  input  logic [63:0]   tweak,
  output logic          ready,
  output logic          tk_valid,
  input  logic          tk_ready,
  output logic [63:0]   tk,
  output logic [RW-1:0] tk_round,
  output logic          tk_last,
  output state_e        dbg_state
);

  localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] idx_q, idx_d;
  logic          dec_q, dec_d;
  logic [63:0]   k0_q, k0_d;
  logic [63:0]   k1_q, k1_d;
  logic [63:0]   t_q, t_d;
  logic [63:0]   qt_q, qt_d;
  logic [63:0]   tk_q, tk_d;
  logic          last_q, last_d;
  logic [63:0]   q_tweak;

  // Q is only needed once per sequence, so it sits on the load path.
  craft_q_perm u_q_perm (
    .t_in  (tweak),
    .q_out (q_tweak)
  );

  // Even rounds use K0, odd rounds K1; rounds with (i mod 4) >= 2 use Q(T).
  function automatic logic [63:0] tk_of(input logic [RW-1:0] idx,
                                        input logic [63:0] k0,
                                        input logic [63:0] k1,
                                        input logic [63:0] t,
                                        input logic [63:0] qt);
    logic [RW:0]  ext;
    logic [63:0]  kx;
    logic [63:0]  tx;
    ext = {1'b0, idx};
    kx  = ext[0] ? k1 : k0;
    tx  = ext[1] ? qt : t;
    return kx ^ tx;
  endfunction

  function automatic logic is_last(input logic [RW-1:0] idx, input logic dec);
    return dec ? (idx == '0) : (idx == LAST_IDX);
  endfunction

  // Next-state, index stepping and registered-output precomputation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    t_d     = t_q;
    qt_d    = qt_q;
    tk_d    = tk_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          dec_d   = decrypt;
          k0_d    = key[127:64];
          k1_d    = key[63:0];
          t_d     = (TWEAK_EN != 0) ? tweak   : 64'd0;
          qt_d    = (TWEAK_EN != 0) ? q_tweak : 64'd0;
          idx_d   = decrypt ? LAST_IDX : '0;
          tk_d    = tk_of(idx_d, k0_d, k1_d, t_d, qt_d);
          last_d  = is_last(idx_d, decrypt);
        end
      end
      ST_RUN: begin
        if (tk_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tk_d    = 64'd0;
            last_d  = 1'b0;
          end else begin
            idx_d  = dec_q ? (idx_q - RW'(1)) : (idx_q + RW'(1));
            tk_d   = tk_of(idx_d, k0_q, k1_q, t_q, qt_q);
            last_d = is_last(idx_d, dec_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      k0_q    <= 64'd0;
      k1_q    <= 64'd0;
      t_q     <= 64'd0;
      qt_q    <= 64'd0;
      tk_q    <= 64'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      t_q     <= t_d;
      qt_q    <= qt_d;
      tk_q    <= tk_d;
      last_q  <= last_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign tk_valid  = (state_q == ST_RUN);
  assign tk        = tk_q;
  assign tk_round  = idx_q;
  assign tk_last   = last_q;
  assign dbg_state = state_q;

endmodule

// File: doc/craft_tweakey_gen.md
CRAFT_TWEAKEY_GEN -- requirements
Module: craft_tweakey_gen

Interface
REQ-001 Parameter ROUNDS, default 32: number of round tweakeys per sequence; legal range 1..255.
REQ-002 Parameter TWEAK_EN, default 1: 1 = tweak is XORed into TK; 0 = TK is key half only (tweak and Q path ignored).
REQ-003 Parameter RW, default 8: width of the round-index port; must satisfy 2^RW > ROUNDS.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new tweakey sequence.
REQ-007 decrypt  input  1  sampled with start; 1 = emit rounds ROUNDS-1 down to 0.
REQ-008 key  input  128  master key, sampled with start; K0 = key[127:64], K1 = key[63:0].
REQ-009 tweak  input  64  tweak, sampled with start.
REQ-010 ready  output  1  high when a start is acceptable (IDLE).
REQ-011 tk_valid  output  1  tk/tk_round/tk_last are valid.
REQ-012 tk_ready  input  1  consumer accepts the current TK.
REQ-013 tk  output  64  round tweakey.
REQ-014 tk_round  output  RW  round index i of the current tk.
REQ-015 tk_last  output  1  current tk is the final one of the sequence.

Function
REQ-016 States: IDLE, RUN; ready = (state == IDLE); tk_valid = (state == RUN).
REQ-017 In IDLE, start=1 is accepted on a rising edge: key, tweak, decrypt are registered; Q(tweak) is computed once and registered; state -> RUN.
REQ-018 start while in RUN is ignored with no effect on the sequence in progress.
REQ-019 First TK is valid the cycle after the start edge (latency 1); i = 0 when decrypt=0, else i = ROUNDS-1.
REQ-020 TK(i) = Kx XOR Tx, where Kx = K0 if i even, else K1; Tx = tweak if (i mod 4) < 2, else Q(tweak); Tx = 0 when TWEAK_EN = 0.
REQ-021 Q maps output nibble j to input nibble P[j], with nibble 0 = bits 63:60 and P = 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
REQ-022 A TK transfers when tk_valid and tk_ready are both high on a clock edge; i then steps +1 (encrypt) or -1 (decrypt).
REQ-023 With tk_valid high and tk_ready low, tk, tk_round and tk_last hold stable.
REQ-024 tk_last = 1 iff i = ROUNDS-1 (encrypt) or i = 0 (decrypt); for ROUNDS = 1 the single TK has tk_last = 1.
REQ-025 Transfer with tk_last = 1 returns to IDLE; ready rises the next cycle; the index never wraps.
REQ-026 tk, tk_round and tk_last are registered outputs driving 0 whenever tk_valid = 0.

Reset
REQ-027 rst asserted at any time, including mid-sequence, forces IDLE within the same cycle (asynchronously).
REQ-028 On reset, all key/tweak/Q registers clear to 0; outputs: ready=1, tk_valid=0, tk=0, tk_round=0, tk_last=0.
REQ-029 After reset deassertion, the first accepted start begins a fresh sequence; no state is retained.

Structure
REQ-030 A shared package craft_pkg holds the P permutation table, the nibble/state width constants, and the state enum.
REQ-031 One sub-module, craft_q_perm, implements the purely combinational 64-bit Q permutation; it is instantiated once, on the load path.

Verification
REQ-032 key=0, tweak=0x0123456789ABCDEF, encrypt, tk_ready=1 -> i0 TK=0x0123456789ABCDEF; i2 TK=0xCAF5E892B374601D; i4 TK=0x0123456789ABCDEF.
REQ-033 key=0xFFFFFFFFFFFFFFFF_0000000000000000, tweak=0, encrypt -> 32 TKs alternating 0xFFFFFFFFFFFFFFFF / 0; tk_last only at i=31; ready=1 on the following cycle.
REQ-034 Same stimulus as REQ-032 with decrypt=1 -> first TK has i=31, i.e. K1 XOR Q(T) = 0xCAF5E892B374601D; last TK has i=0, value 0x0123456789ABCDEF.
REQ-035 tk_ready toggled randomly -> TK values are held while stalled, no TK is skipped or duplicated, and a start issued during RUN is ignored.
REQ-036 rst asserted at i=10 -> tk_valid=0 and ready=1 immediately; a new start yields i=0 in the next cycle.
REQ-037 ROUNDS=1 and TWEAK_EN=0 -> one TK equal to K0 with tk_last=1, then IDLE.
